// File: rtl/audio_pkg.sv
// Shared audio-path definitions used by the oscillator, mixer and PDM sink.
package audio_pkg;

  localparam int unsigned AUDIO_BITDEPTH = 12;

  typedef logic [AUDIO_BITDEPTH-1:0] audio_sample_t;

  // Offset-binary "silence" level: 2^(bits-1)-1.
  function automatic int unsigned audio_midpoint(input int unsigned bits);
    return (32'd1 << (bits - 32'd1)) - 32'd1;
  endfunction

  localparam audio_sample_t AUDIO_MIDPOINT = audio_sample_t'(audio_midpoint(AUDIO_BITDEPTH));

endpackage

// File: rtl/audio_pdm_sink_if.sv
// Valid/ready sample stream from the mixer into the PDM sink.
interface audio_pdm_sink_if
  import audio_pkg::*;
#(
  parameter int unsigned BITDEPTH = AUDIO_BITDEPTH
);

  logic [BITDEPTH-1:0] sample_in;
  logic                sample_valid;
  logic                sample_ready;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/audio_sample_fifo.sv
// Synchronous power-of-two FIFO with registered level, full and empty flags.
module audio_sample_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rd_ptr];

  assign w_wr = i_wr_en && !o_full;
  assign w_rd = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/audio_pdm_sink.sv
// Audio output sink: buffers mixer samples, releases one per sample period,
// and converts it to a 1-bit stream with a first-order delta-sigma modulator.
module audio_pdm_sink
  import audio_pkg::*;
#(
  parameter int unsigned BITDEPTH   = AUDIO_BITDEPTH,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CLK_DIV    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  audio_pdm_sink_if.slave               s_if,
  output logic                          sample_tick,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          pdm_out
);

  localparam int unsigned          DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0]        DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BITDEPTH-1:0]  MIDPOINT = BITDEPTH'(audio_midpoint(BITDEPTH));

  logic [DW-1:0]       r_div_cnt;
  logic                r_tick;
  logic                r_underrun;
  logic [BITDEPTH-1:0] r_cur;
  logic [BITDEPTH:0]   r_acc;

  logic [BITDEPTH:0]   w_sum;
  logic [BITDEPTH-1:0] w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_push;

  assign s_if.sample_ready = !w_full;
  assign w_push            = s_if.sample_valid && !w_full;

  audio_sample_fifo #(
    .WIDTH (BITDEPTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_push),
    .i_wr_data (s_if.sample_in),
    .i_rd_en   (r_tick),
    .o_rd_data (w_head),
    .o_level   (fifo_level),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_sum = {1'b0, r_acc[BITDEPTH-1:0]} + {1'b0, r_cur};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_tick     <= 1'b0;
      r_underrun <= 1'b0;
      r_cur      <= MIDPOINT;
      r_acc      <= '0;
    end else begin
      r_div_cnt  <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DW'(1);
      r_tick     <= (r_div_cnt == DIV_LAST);
      r_underrun <= r_tick && w_empty;
      if (r_tick && !w_empty) r_cur <= w_head;
      r_acc      <= w_sum;
    end
  end

  // The stored carry bit is exactly the registered modulator output, so no
  // separate pdm flop is kept.
  assign pdm_out     = r_acc[BITDEPTH];
  assign sample_tick = r_tick;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_audio_pdm_sink.sv
// Bench for audio_pdm_sink: directed vectors plus randomized traffic checked
// against a queue/arithmetic model of the sink.
module tb_audio_pdm_sink;
  import audio_pkg::*;

  localparam int unsigned A_DIV = 16;
  localparam int unsigned B_DIV = 4096;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MID   = 2047;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       tick_a, under_a, pdm_a;
  logic       tick_b, under_b, pdm_b;
  logic [2:0] lvl_a, lvl_b;

  audio_pdm_sink_if #(.BITDEPTH(12)) if_a ();
  audio_pdm_sink_if #(.BITDEPTH(12)) if_b ();

  audio_pdm_sink #(.BITDEPTH(12), .FIFO_DEPTH(DEPTH), .CLK_DIV(A_DIV)) dut_a (
    .clk(clk), .rst(rst_a), .s_if(if_a),
    .sample_tick(tick_a), .fifo_level(lvl_a), .underrun(under_a), .pdm_out(pdm_a)
  );

  audio_pdm_sink #(.BITDEPTH(12), .FIFO_DEPTH(DEPTH), .CLK_DIV(B_DIV)) dut_b (
    .clk(clk), .rst(rst_b), .s_if(if_b),
    .sample_tick(tick_b), .fifo_level(lvl_b), .underrun(under_b), .pdm_out(pdm_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model for dut_a: cycles since reset, a sample queue, and the
  // running sum of cur values whose 4096-boundary crossings are the pdm ones.
  int unsigned m_cnt;
  logic [11:0] m_q[$];
  int unsigned m_cur;
  longint      m_total;
  bit          m_pdm, m_under;
  bit          chk_on;

  function automatic bit m_tick();
    return (m_cnt != 0) && ((m_cnt % A_DIV) == 0);
  endfunction

  task automatic model_step();
    bit tk, rdy;
    longint t_old;
    if (rst_a) begin
      m_cnt = 0; m_q.delete(); m_cur = MID; m_total = 0; m_pdm = 0; m_under = 0;
    end else begin
      tk      = m_tick();
      rdy     = (m_q.size() < DEPTH);
      m_under = tk && (m_q.size() == 0);
      t_old   = m_total;
      m_total = m_total + m_cur;
      m_pdm   = (m_total / 4096) != (t_old / 4096);
      if (tk && m_q.size() != 0) m_cur = m_q.pop_front();
      if (if_a.sample_valid && rdy) m_q.push_back(if_a.sample_in);
      m_cnt++;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    model_step();
    #1;
    if (chk_on) begin
      check("m_tick",     tick_a, m_tick());
      check("m_level",    lvl_a, m_q.size());
      check("m_ready",    if_a.sample_ready, m_q.size() < DEPTH);
      check("m_underrun", under_a, m_under);
      check("m_pdm",      pdm_a, m_pdm);
    end
  endtask

  task automatic wait_tick_a(input int bound);
    int k = 0;
    while (!tick_a && k < bound) begin
      next_cycle();
      k++;
    end
    check("tick_wait", tick_a, 1);
  endtask

  typedef struct {
    bit          valid;
    logic [11:0] data;
    bit          exp_ready;
    int          exp_level;
  } vec_t;

  vec_t vt[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, ones, ucnt, k;
    int ones_b[4];

    vt[0] = '{1'b1, 12'h111, 1'b1, 0};
    vt[1] = '{1'b1, 12'hABC, 1'b1, 1};
    vt[2] = '{1'b1, 12'h005, 1'b1, 2};
    vt[3] = '{1'b1, 12'hFFF, 1'b1, 3};
    vt[4] = '{1'b1, 12'h777, 1'b0, 4};
    vt[5] = '{1'b1, 12'h777, 1'b0, 4};
    vt[6] = '{1'b0, 12'h000, 1'b0, 4};

    rst_a = 1'b1; rst_b = 1'b1; chk_on = 1'b0;
    if_a.sample_valid = 1'b0; if_a.sample_in = '0;
    if_b.sample_valid = 1'b0; if_b.sample_in = '0;
    next_cycle();
    next_cycle();
    chk_on = 1'b1;

    // Reset state
    check("rst_level", lvl_a, 0);
    check("rst_ready", if_a.sample_ready, 1);
    check("rst_tick", tick_a, 0);
    check("rst_underrun", under_a, 0);
    check("rst_pdm", pdm_a, 0);

    // Idle after reset: tick timing, underruns, midpoint density
    rst_a = 1'b0;
    first = 0; ones = 0; ucnt = 0;
    for (int n = 1; n <= 4096; n++) begin
      next_cycle();
      ones += int'(pdm_a);
      ucnt += int'(under_a);
      if (tick_a && first == 0) first = n;
    end
    check("first_tick", first, 16);
    check("ones_mid", ones, 2047);
    check("underrun_count", ucnt, 255);

    // Fill to full from the table
    wait_tick_a(40);
    next_cycle();
    for (int i = 0; i < 7; i++) begin
      check("vec_ready", if_a.sample_ready, vt[i].exp_ready);
      check("vec_level", lvl_a, vt[i].exp_level);
      if_a.sample_valid = vt[i].valid;
      if_a.sample_in    = vt[i].data;
      next_cycle();
    end
    wait_tick_a(40);
    check("full_tick_level", lvl_a, 4);
    check("full_tick_ready", if_a.sample_ready, 0);
    next_cycle();
    check("pop_level", lvl_a, 3);
    check("pop_ready", if_a.sample_ready, 1);
    check("pop_underrun", under_a, 0);

    // Full FIFO with a push held across a tick
    if_a.sample_valid = 1'b1; if_a.sample_in = 12'h0C3;
    next_cycle();
    check("refill_level", lvl_a, 4);
    if_a.sample_in = 12'h3C0;
    wait_tick_a(40);
    check("tick_full_ready", if_a.sample_ready, 0);
    next_cycle();
    check("tick_full_level", lvl_a, 3);
    check("tick_full_ready2", if_a.sample_ready, 1);
    next_cycle();
    check("late_push_level", lvl_a, 4);
    if_a.sample_valid = 1'b0;

    // Push 0x800 on a tick that finds the FIFO empty
    k = 0;
    while (!(tick_a && lvl_a == 0) && k < 200) begin
      next_cycle();
      k++;
    end
    check("empty_tick_found", int'(tick_a && lvl_a == 0), 1);
    if_a.sample_valid = 1'b1; if_a.sample_in = 12'h800;
    next_cycle();
    if_a.sample_valid = 1'b0;
    check("empty_push_underrun", under_a, 1);
    check("empty_push_level", lvl_a, 1);
    repeat (7) next_cycle();
    check("held_level", lvl_a, 1);
    wait_tick_a(40);
    next_cycle();
    check("load_level", lvl_a, 0);
    check("load_underrun", under_a, 0);
    next_cycle();
    ones = 0;
    for (int n = 0; n < 4096; n++) begin
      ones += int'(pdm_a);
      next_cycle();
    end
    check("ones_0x800", ones, 2048);

    // Reset mid-stream with three samples queued
    wait_tick_a(40);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      if_a.sample_valid = 1'b1;
      if_a.sample_in    = 12'($urandom_range(1, 4095));
      next_cycle();
    end
    if_a.sample_valid = 1'b0;
    check("queued_level", lvl_a, 3);
    rst_a = 1'b1;
    next_cycle();
    check("midrst_level", lvl_a, 0);
    check("midrst_pdm", pdm_a, 0);
    check("midrst_ready", if_a.sample_ready, 1);
    rst_a = 1'b0;
    first = 0;
    for (int n = 1; n <= 40; n++) begin
      next_cycle();
      if (tick_a && first == 0) first = n;
    end
    check("midrst_first_tick", first, 16);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if_a.sample_valid = ($urandom_range(0, (i < 750) ? 3 : 31) == 0);
      if_a.sample_in    = 12'($urandom_range(0, 4095));
      rst_a             = ($urandom_range(0, 399) == 0);
      next_cycle();
    end
    rst_a = 1'b0;
    if_a.sample_valid = 1'b0;

    // Density per period at CLK_DIV=4096 for samples 0, 4095, 1024
    rst_b = 1'b0;
    if_b.sample_valid = 1'b1; if_b.sample_in = 12'd0;
    next_cycle();
    if_b.sample_in = 12'd4095;
    next_cycle();
    if_b.sample_in = 12'd1024;
    next_cycle();
    if_b.sample_valid = 1'b0;
    check("b_level", lvl_b, 3);
    first = 0; ucnt = 0;
    for (int k2 = 0; k2 < 4; k2++) ones_b[k2] = 0;
    for (int n = 4; n <= 16385; n++) begin
      next_cycle();
      if (tick_b && first == 0) first = n;
      if (n <= 16384) ucnt += int'(under_b);
      for (int s = 1; s <= 3; s++)
        if (n >= s * 4096 + 2 && n <= s * 4096 + 4097) ones_b[s] += int'(pdm_b);
      if (n == 16385) check("b_final_underrun", under_b, 1);
    end
    check("b_first_tick", first, 4096);
    check("b_no_early_underrun", ucnt, 0);
    check("b_ones_0", ones_b[1], 0);
    check("b_ones_4095", ones_b[2], 4095);
    check("b_ones_1024", ones_b[3], 1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_pdm_sink.md
# audio_pdm_sink

Output-end consumer for the synth voice path. Oscillator/mixer samples arrive over a valid/ready handshake into a small FIFO. They are released at a fixed sample rate derived from the system clock and converted to a 1-bit pulse-density stream by a first-order delta-sigma modulator. `pdm_out` drives the badge audio pin through an external RC filter.

## Interface
- `BITDEPTH`, default 12: sample width in bits, unsigned, offset-binary.
- `FIFO_DEPTH`, default 4: sample buffer entries; must be a power of two, ≥2.
- `CLK_DIV`, default 1024: `clk` cycles per output sample; must be ≥2.

- `clk`, in, 1: system clock. One clock domain only; synchronous, active-high reset.
- `rst`, in, 1: synchronous, active-high reset.
- `sample_in`, in, `BITDEPTH`: sample from the mixer.
- `sample_valid`, in, 1: `sample_in` is valid this cycle.
- `sample_ready`, out, 1: the FIFO can accept a sample this cycle.
- `sample_tick`, out, 1: one-cycle pulse at each sample-period boundary. The mixer may use it as its sample-clock enable.
- `fifo_level`, out, `$clog2(FIFO_DEPTH)+1`: current number of FIFO entries.
- `underrun`, out, 1: one-cycle pulse when a tick finds the FIFO empty.
- `pdm_out`, out, 1: registered 1-bit modulator output.

## Operation
- Reset values:
  - FIFO empty; `fifo_level`=0; `sample_ready`=1.
  - Divider count=0; `sample_tick`=0; `underrun`=0.
  - Current sample `cur`=MIDPOINT (2^(BITDEPTH-1)-1, i.e. 2047 at default).
  - Accumulator `acc`=0; `pdm_out`=0.
- Push: when `sample_valid && sample_ready`, write `sample_in` at the write pointer, which then increments modulo `FIFO_DEPTH`.
- `sample_ready` = !full. It is derived from registered level only and has no combinational path from `sample_valid`.
- Divider: counts 0..`CLK_DIV`-1, then wraps to 0. `sample_tick` is registered and asserts in the cycle after the count reaches `CLK_DIV`-1.
- Pop: on a cycle with `sample_tick`=1:
  - FIFO non-empty: `cur` takes the head entry and the read pointer increments.
  - FIFO empty: `cur` holds its previous value (no jump to MIDPOINT) and `underrun` pulses in the following cycle.
- Simultaneous push and pop: the level is unchanged; both pointers advance.
- Push into an empty FIFO on a tick cycle: there is no bypass. The tick counts as an underrun and the pushed sample is kept for the next tick.
- Modulator, every `clk` cycle:
  - `acc` is `BITDEPTH`+1 bits wide.
  - Update: `acc` <= {1'b0, `acc`[BITDEPTH-1:0]} + `cur`.
  - `pdm_out` <= carry bit `acc`[BITDEPTH] of the new sum.
  - For a constant `cur`=v, any 2^BITDEPTH consecutive cycles contain exactly v ones. v=0 gives a constant 0; v=2^BITDEPTH-1 gives exactly one 0 per period.
- Reset mid-operation: all state returns to the reset values on the next edge. Queued samples are discarded and `pdm_out`=0 in the cycle after `rst`.

## Timing
- `sample_tick` pulse width: exactly 1 cycle, period `CLK_DIV` cycles. The first tick comes `CLK_DIV` cycles after reset deasserts.
- `cur` updates on the edge that samples `sample_tick`=1, i.e. tick cycle +1.
- `pdm_out` reflects a new `cur` from tick cycle +2.
- `fifo_level` and `sample_ready` update the cycle after a push or pop.
- Throughput: one push per cycle while not full. Sustained rate is 1 sample per `CLK_DIV` cycles.

## Structure
- Shared package `audio_pkg` holds:
  - `AUDIO_BITDEPTH` (12);
  - `audio_sample_t` (logic [AUDIO_BITDEPTH-1:0]);
  - the MIDPOINT constant.
  The oscillator and the mixer use the same package.
- Sub-module `audio_sample_fifo`: parameterised synchronous FIFO with pointers, level, full and empty. The divider and modulator stay in the top module.

## Test plan
- Reset, then no pushes, `CLK_DIV`=16:
  - first `sample_tick` at cycle 16 after reset release;
  - `underrun` pulses at each tick;
  - with `cur`=2047, `pdm_out` has 2047 ones per 4096 cycles.
- Push 4 samples back-to-back (`FIFO_DEPTH`=4):
  - `sample_ready` drops after the 4th;
  - a 5th `sample_valid` is held off;
  - `fifo_level`=4;
  - the next tick pops and `sample_ready` returns to 1 the cycle after.
- Push 0, 4095, 1024 before the first ticks, `CLK_DIV`=4096:
  - per period, `pdm_out` ones count = 0, 4095, 1024;
  - `cur` changes at tick cycle +1.
- On a tick cycle with the FIFO empty, push 0x800:
  - `underrun` pulses;
  - `cur` unchanged;
  - 0x800 loads at the next tick;
  - `fifo_level` reads 1 in between.
- Full FIFO with a push presented on a tick cycle: the push is not accepted that cycle, the pop occurs, and the push is accepted the following cycle.
- Assert `rst` for 1 cycle mid-stream with 3 samples queued:
  - next cycle `fifo_level`=0 and `pdm_out`=0;
  - the divider restarts, with the first tick `CLK_DIV` cycles later.
